// File: rtl/dot_prod_host_pkg.sv
// rtl/dot_prod_host_pkg.sv - shared constants, types and FSM states for the dot-product host
package dot_prod_pkg;

    localparam int N  = 1000;
    localparam int AW = 10;
    localparam int DW = 27;
    localparam int RW = 64;

    typedef logic signed [DW-1:0] elem_t;
    typedef logic signed [RW-1:0] acc_t;
    typedef logic        [AW-1:0] addr_t;

    typedef enum logic [2:0] {
        LOAD,
        FILL,
        START,
        RUN,
        DONE
    } state_t;

    localparam addr_t LAST_ADDR = addr_t'(N - 1);

    // Saturating step: the array index never wraps past the last slot.
    function automatic addr_t next_addr(input addr_t a);
        return (a == LAST_ADDR) ? a : a + addr_t'(1);
    endfunction

endpackage

// File: rtl/dot_prod_host_if.sv
// rtl/dot_prod_host_if.sv - element stream, result stream and accelerator control-port bundle
interface dot_prod_host_if;
    import dot_prod_pkg::*;

    logic  in_valid;
    logic  in_ready;
    elem_t in_a;
    elem_t in_b;
    logic  in_last;

    logic  res_valid;
    logic  res_ready;
    acc_t  res_data;
    logic  res_err;

    logic  acc_r_enable;
    logic  acc_control_arr;
    addr_t acc_init_i;
    acc_t  acc_init_acc;
    logic  acc_we_a;
    logic  acc_we_b;
    addr_t acc_addr_a;
    addr_t acc_addr_b;
    elem_t acc_wdata_a;
    elem_t acc_wdata_b;
    logic  acc_w_enable;
    acc_t  acc_result;

    modport master (
        input  in_valid, in_a, in_b, in_last,
        output in_ready,
        output res_valid, res_data, res_err,
        input  res_ready,
        output acc_r_enable, acc_control_arr, acc_init_i, acc_init_acc,
        output acc_we_a, acc_we_b, acc_addr_a, acc_addr_b, acc_wdata_a, acc_wdata_b,
        input  acc_w_enable, acc_result
    );

    modport slave (
        output in_valid, in_a, in_b, in_last,
        input  in_ready,
        input  res_valid, res_data, res_err,
        output res_ready,
        input  acc_r_enable, acc_control_arr, acc_init_i, acc_init_acc,
        input  acc_we_a, acc_we_b, acc_addr_a, acc_addr_b, acc_wdata_a, acc_wdata_b,
        output acc_w_enable, acc_result
    );

endinterface

// File: rtl/dot_prod_host_wport.sv
// rtl/dot_prod_host_wport.sv - registered write-port driver shared by both accelerator arrays
module dot_prod_host_wport
    import dot_prod_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  elem_t wr_a,
    input  elem_t wr_b,
    output logic  we,
    output addr_t addr,
    output elem_t wdata_a,
    output elem_t wdata_b
);

    // Address and data hold their last value between writes; only we is a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we      <= 1'b0;
            addr    <= '0;
            wdata_a <= '0;
            wdata_b <= '0;
        end else begin
            we <= wr_en;
            if (wr_en) begin
                addr    <= wr_addr;
                wdata_a <= wr_a;
                wdata_b <= wr_b;
            end
        end
    end

endmodule

// File: rtl/dot_prod_host.sv
// rtl/dot_prod_host.sv - loads a/b arrays, starts the accelerator and returns its result; option DOT_PROD_HOST_TIMEOUT_EN
module dot_prod_host
    import dot_prod_pkg::*;
#(
    parameter int TIMEOUT = 65535
)
(
    input  logic            clk,
    input  logic            rst,
    dot_prod_host_if.master bus
);

    state_t state, state_n;
    addr_t  cnt, cnt_n;
    logic   ctrl_q, ctrl_n;
    logic   ren_q, ren_n;
    logic   res_valid_q, res_valid_n;
    acc_t   res_data_q, res_data_n;

    logic   wr_en;
    elem_t  wr_a;
    elem_t  wr_b;
    logic   we;
    addr_t  addr;
    elem_t  wdata_a;
    elem_t  wdata_b;

`ifdef DOT_PROD_HOST_TIMEOUT_EN
    logic        res_err_q, res_err_n;
    logic [31:0] run_cnt, run_cnt_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            cnt         <= '0;
            ctrl_q      <= 1'b1;
            ren_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef DOT_PROD_HOST_TIMEOUT_EN
            res_err_q   <= 1'b0;
            run_cnt     <= '0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ctrl_q      <= ctrl_n;
            ren_q       <= ren_n;
            res_valid_q <= res_valid_n;
            res_data_q  <= res_data_n;
`ifdef DOT_PROD_HOST_TIMEOUT_EN
            res_err_q   <= res_err_n;
            run_cnt     <= run_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ctrl_n      = ctrl_q;
        ren_n       = 1'b0;
        res_valid_n = res_valid_q;
        res_data_n  = res_data_q;
        wr_en       = 1'b0;
        wr_a        = '0;
        wr_b        = '0;
`ifdef DOT_PROD_HOST_TIMEOUT_EN
        res_err_n   = res_err_q;
        run_cnt_n   = run_cnt;
`endif
        case (state)
            LOAD: begin
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    wr_a  = bus.in_a;
                    wr_b  = bus.in_b;
                    cnt_n = next_addr(cnt);
                    if (cnt == LAST_ADDR) begin
                        state_n = START;
                    end else if (bus.in_last) begin
                        state_n = FILL;
                    end
                end
            end
            FILL: begin
                wr_en = 1'b1;
                cnt_n = next_addr(cnt);
                if (cnt == LAST_ADDR) begin
                    state_n = START;
                end
            end
            START: begin
                ctrl_n  = 1'b0;
                ren_n   = 1'b1;
                state_n = RUN;
`ifdef DOT_PROD_HOST_TIMEOUT_EN
                run_cnt_n = '0;
`endif
            end
            RUN: begin
                if (bus.acc_w_enable && !ren_q) begin
                    res_data_n  = bus.acc_result;
                    res_valid_n = 1'b1;
                    state_n     = DONE;
                end
`ifdef DOT_PROD_HOST_TIMEOUT_EN
                else if (run_cnt == 32'(TIMEOUT - 1)) begin
                    res_data_n  = '0;
                    res_err_n   = 1'b1;
                    res_valid_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    run_cnt_n = run_cnt + 32'd1;
                end
`endif
            end
            DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_n = 1'b0;
                    ctrl_n      = 1'b1;
                    cnt_n       = '0;
                    state_n     = LOAD;
`ifdef DOT_PROD_HOST_TIMEOUT_EN
                    res_err_n   = 1'b0;
`endif
                end
            end
            default: state_n = LOAD;
        endcase
    end

    dot_prod_host_wport u_wport (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (cnt),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .we      (we),
        .addr    (addr),
        .wdata_a (wdata_a),
        .wdata_b (wdata_b)
    );

    assign bus.in_ready        = (state == LOAD);
    assign bus.res_valid       = res_valid_q;
    assign bus.res_data        = res_data_q;
    assign bus.acc_r_enable    = ren_q;
    assign bus.acc_control_arr = ctrl_q;
    assign bus.acc_init_i      = '0;
    assign bus.acc_init_acc    = '0;
    assign bus.acc_we_a        = we;
    assign bus.acc_we_b        = we;
    assign bus.acc_addr_a      = addr;
    assign bus.acc_addr_b      = addr;
    assign bus.acc_wdata_a     = wdata_a;
    assign bus.acc_wdata_b     = wdata_b;

`ifdef DOT_PROD_HOST_TIMEOUT_EN
    assign bus.res_err = res_err_q;
`else
    assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_dot_prod_host.sv
// tb/tb_dot_prod_host.sv - directed and random vectors against a behavioural accelerator and dot-product model
module tb_dot_prod_host;
    import dot_prod_pkg::*;

    logic clk;
    logic rst;
    logic acc_rst;
    logic clr_stats;
    logic stall;

    dot_prod_host_if bus ();

    dot_prod_host #(.TIMEOUT(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    elem_t mem_a [N];
    elem_t mem_b [N];
    int    wr_cnt [N];
    int    bad_wr;
    int    r_pulses;
    int    r_width;
    int    r_run;
    int    busy;
    logic  acc_done;
    acc_t  acc_res;
    logic signed [63:0] acc_sum;

    assign bus.acc_w_enable = acc_done;
    assign bus.acc_result   = acc_res;

    always @(posedge clk) begin
        if (acc_rst) begin
            acc_done <= 1'b0;
            acc_res  <= '0;
            busy = 0;
        end
        if (clr_stats) begin
            for (int i = 0; i < N; i++) wr_cnt[i] = 0;
            bad_wr = 0;
            r_pulses = 0;
            r_width = 0;
            r_run = 0;
        end else begin
            if (bus.acc_we_a || bus.acc_we_b) begin
                if (bus.acc_control_arr && bus.acc_we_a && bus.acc_we_b &&
                    bus.acc_addr_a == bus.acc_addr_b && int'(bus.acc_addr_a) < N) begin
                    mem_a[bus.acc_addr_a] = bus.acc_wdata_a;
                    mem_b[bus.acc_addr_a] = bus.acc_wdata_b;
                    wr_cnt[bus.acc_addr_a]++;
                end else begin
                    bad_wr++;
                end
            end
            if (bus.acc_r_enable) begin
                if (r_run == 0) r_pulses++;
                r_run++;
                if (r_run > r_width) r_width = r_run;
            end else begin
                r_run = 0;
            end
        end
        if (bus.acc_r_enable) begin
            acc_done <= 1'b0;
            acc_sum = bus.acc_init_acc;
            for (int i = int'(bus.acc_init_i); i < N; i++)
                acc_sum += 64'(longint'(mem_a[i]) * longint'(mem_b[i]));
            busy = $urandom_range(2, 9);
        end else if (busy > 0) begin
            busy--;
            if (busy == 0 && !stall) begin
                acc_done <= 1'b1;
                acc_res  <= acc_sum;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    elem_t qa[$];
    elem_t qb[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
    endtask

    task automatic load_vec();
        for (int i = 0; i < qa.size(); i++) begin
            int guard;
            guard = 0;
            bus.in_valid = 1'b1;
            bus.in_a     = qa[i];
            bus.in_b     = qb[i];
            bus.in_last  = (i == qa.size() - 1);
            while (bus.in_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) chk("in_ready_wait", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic signed [63:0] exp,
                               input logic exp_err, input bit hold);
        int guard;
        guard = 0;
        while (bus.res_valid !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_res_valid"}, bus.res_valid, 1);
        chk({tag, "_res_data"}, bus.res_data, exp);
        chk({tag, "_res_err"}, bus.res_err, exp_err);
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, bus.res_valid, 1);
                chk({tag, "_hold_data"}, bus.res_data, exp);
                chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
            end
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({tag, "_after_valid"}, bus.res_valid, 0);
        chk({tag, "_after_ctrl"}, bus.acc_control_arr, 1);
        chk({tag, "_after_in_ready"}, bus.in_ready, 1);
    endtask

    task automatic check_stats(input string tag);
        int bad;
        elem_t ea, eb;
        bad = 0;
        for (int i = 0; i < N; i++) if (wr_cnt[i] != 1) bad++;
        chk({tag, "_addr_written_once"}, bad, 0);
        chk({tag, "_stray_writes"}, bad_wr, 0);
        chk({tag, "_start_pulses"}, r_pulses, 1);
        chk({tag, "_start_width"}, r_width, 1);
        bad = 0;
        for (int i = 0; i < N; i++) begin
            ea = (i < qa.size()) ? qa[i] : elem_t'(0);
            eb = (i < qb.size()) ? qb[i] : elem_t'(0);
            if (mem_a[i] !== ea || mem_b[i] !== eb) bad++;
        end
        chk({tag, "_array_contents"}, bad, 0);
    endtask

    task automatic run_vec(input string tag, input bit hold, input bit extra);
        logic signed [63:0] exp_sum;
        exp_sum = 0;
        for (int i = 0; i < qa.size(); i++)
            exp_sum += 64'(longint'(qa[i]) * longint'(qb[i]));
        clear_stats();
        load_vec();
        if (extra) begin
            bus.in_valid = 1'b1;
            bus.in_a     = elem_t'(12345);
            bus.in_b     = elem_t'(-777);
            chk({tag, "_extra_in_ready"}, bus.in_ready, 0);
            repeat (3) @(negedge clk);
            bus.in_valid = 1'b0;
        end
        wait_result(tag, exp_sum, 1'b0, hold);
        check_stats(tag);
    endtask

    initial begin
        int guard;
        rst           = 1'b1;
        acc_rst       = 1'b1;
        clr_stats     = 1'b1;
        stall         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_control_arr", bus.acc_control_arr, 1);
        chk("rst_r_enable", bus.acc_r_enable, 0);
        chk("rst_we", bus.acc_we_a | bus.acc_we_b, 0);
        chk("rst_addr", bus.acc_addr_a, 0);
        chk("rst_wdata", bus.acc_wdata_a, 0);
        chk("rst_init_i", bus.acc_init_i, 0);
        chk("rst_init_acc", bus.acc_init_acc, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_err", bus.res_err, 0);

        rst       = 1'b0;
        acc_rst   = 1'b0;
        clr_stats = 1'b0;
        @(negedge clk);

        qa.delete(); qb.delete();
        for (int i = 0; i < N; i++) begin
            qa.push_back(elem_t'(i));
            qb.push_back(elem_t'(1));
        end
        run_vec("full", 1'b0, 1'b1);

        qa = {elem_t'(2), elem_t'(-4), elem_t'(7)};
        qb = {elem_t'(3), elem_t'(5), elem_t'(-1)};
        run_vec("three", 1'b0, 1'b0);

        qa = {elem_t'(-67108864)};
        qb = {elem_t'(2)};
        run_vec("sign", 1'b1, 1'b0);

        for (int v = 0; v < 3; v++) begin
            int len;
            len = $urandom_range(1, 60);
            qa.delete(); qb.delete();
            for (int i = 0; i < len; i++) begin
                qa.push_back(elem_t'($urandom));
                qb.push_back(elem_t'($urandom));
            end
            run_vec("random", 1'b0, 1'b0);
        end

        qa = {elem_t'(7)};
        qb = {elem_t'(3)};
        clear_stats();
        load_vec();
        guard = 0;
        while (!(bus.acc_we_a === 1'b1 && bus.acc_addr_a === addr_t'(499)) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("fill_reached_499", bus.acc_addr_a, 499);
        rst = 1'b1;
        #1;
        chk("midrst_control_arr", bus.acc_control_arr, 1);
        chk("midrst_r_enable", bus.acc_r_enable, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_we", bus.acc_we_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        qa = {elem_t'(5)};
        qb = {elem_t'(5)};
        run_vec("rst_recover", 1'b0, 1'b0);

`ifdef DOT_PROD_HOST_TIMEOUT_EN
        stall = 1'b1;
        qa = {elem_t'(1)};
        qb = {elem_t'(1)};
        clear_stats();
        load_vec();
        wait_result("timeout", 0, 1'b1, 1'b0);
        stall = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_prod_host.md
Name: dot_prod_host

Overview:
- Host-side driver for the dot-product accelerator; it owns the other end of the accelerator's control-array, start and done interface.
- Accepts a stream of (a, b) element pairs on a valid/ready interface.
- Writes the pairs into the accelerator's two array memories through the control ports and zero-fills any unused tail.
- Pulses start, waits for done, then returns the 64-bit signed result on a valid/ready output.

Parameters:
N, 1000, vector length / array depth in the accelerator
AW, 10, address width, ceil(log2(N))
DW, 27, signed element width
RW, 64, signed result width
TIMEOUT, 65535, watchdog limit in cycles (used only when the optional feature is enabled)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  element pair valid
in_ready  out  1  host can accept an element pair
in_a  in  DW  signed element for array a
in_b  in  DW  signed element for array b
in_last  in  1  final pair of this vector
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  RW  signed dot product
res_err  out  1  result invalid because of timeout (always 0 without the optional feature)
acc_r_enable  out  1  accelerator start pulse
acc_control_arr  out  1  host owns the array ports
acc_init_i  out  AW  start index, constant 0
acc_init_acc  out  RW  initial accumulator, constant 0
acc_we_a / acc_we_b  out  1  array write enables
acc_addr_a / acc_addr_b  out  AW  array addresses (same value driven on both)
acc_wdata_a / acc_wdata_b  out  DW  array write data
acc_w_enable  in  1  accelerator done (level)
acc_result  in  RW  accelerator result

Behaviour:
- Reset values:
  - state LOAD; cnt 0.
  - acc_control_arr 1; all enables, addresses, write data and init outputs 0.
  - acc_r_enable 0; res_valid 0; res_data 0; res_err 0.
- All acc_* outputs are registered: a write appears on the ports the cycle after it is accepted.
- State LOAD:
  - in_ready = 1.
  - On in_valid & in_ready: register we_a = we_b = 1, addr = cnt, wdata_a = in_a, wdata_b = in_b; cnt++.
  - If cnt == N-1 at acceptance, go to START. This holds whether or not in_last is set.
  - Else if in_last, go to FILL.
  - Otherwise stay in LOAD.
  - Extra pairs beyond N: they are never accepted, because in_ready drops when the state leaves LOAD.
- State FILL:
  - in_ready = 0.
  - One write per cycle: we = 1, wdata = 0, addr = cnt, cnt++.
  - Go to START after the write to address N-1.
- State START (one cycle):
  - Registered outputs: we = 0, acc_control_arr = 0, acc_r_enable = 1.
  - The next state deasserts r_enable.
- State RUN:
  - acc_r_enable = 0; acc_control_arr stays 0.
  - acc_w_enable is sampled only in RUN. The accelerator clears it on the start edge, so a stale done level from the previous run is never seen.
  - On acc_w_enable = 1: res_data <= acc_result, res_valid <= 1, go to DONE.
- State DONE:
  - res_valid holds until res_ready.
  - On res_valid & res_ready: res_valid <= 0, acc_control_arr <= 1, cnt <= 0, go to LOAD.
  - res_data stays stable until the next capture.
- Boundary cases:
  - in_last on the very first pair: writes address 0, then fills 1..N-1.
  - in_valid while not in LOAD: ignored, in_ready = 0.
  - cnt never wraps: it is bounded by N-1 in both LOAD and FILL.
- rst mid-operation: all state returns to reset values immediately. The accelerator is not reset by this block. Its memories are fully rewritten and r_enable is re-pulsed on the next vector, so stale contents never affect a result.
- Arithmetic: none beyond cnt increment; elements pass through unmodified, sign preserved.

Optional Feature:
- Macro: DOT_PROD_HOST_TIMEOUT_EN.
- Defined:
  - A RUN-cycle counter, cleared on entering RUN.
  - If it reaches TIMEOUT without acc_w_enable: res_data <= 0, res_err <= 1, res_valid <= 1, go to DONE.
  - res_err clears on the res handshake.
- Undefined: RUN waits indefinitely; res_err is tied to 0.

Decomposition:
- Shared package dot_prod_pkg:
  - state enum {LOAD, FILL, START, RUN, DONE};
  - constants N, AW, DW, RW;
  - typedefs elem_t (signed DW), acc_t (signed RW), addr_t (AW).
- One sub-module is natural: dot_prod_host_wport, the registered write-port driver. It is instantiated once and drives the identical we/addr/wdata to both arrays.

Test Plan:
- N pairs a[i] = i, b[i] = 1, in_last on i = 999 → 1000 writes, then a one-cycle r_enable; with the accelerator model, res_data = 499500.
- 3 pairs (2,3), (-4,5), (7,-1) with in_last → addresses 3..999 written with 0; res_data = -21.
- Single pair (-67108864, 2) with in_last → full-width sign preserved; res_data = -134217728.
- res_ready held 0 for 10 cycles in DONE → res_valid and res_data stable; in_ready stays 0 until the handshake.
- rst asserted mid-FILL at cnt = 500 → next cycle state LOAD, acc_control_arr = 1, acc_r_enable = 0; a new 1-pair vector (5,5) yields 25.
- With DOT_PROD_HOST_TIMEOUT_EN and TIMEOUT = 16, acc_w_enable held 0 → after 16 RUN cycles res_valid = 1, res_err = 1, res_data = 0.
